ex_mem_stage: RTL and testbench

// - EX->MEM pipeline stage, directly downstream of the 32-bit ALU. Captures the ALU result, flags and control into a 2-entry skid buffer.
// - Resolves conditional branches from the ALU flags and raises a one-cycle PC redirect.
// - Hands the captured bundle to the memory stage over a valid/ready handshake.

---
 rtl/ex_mem_pkg.sv | 59 +++++
 rtl/pipe_skid_buf.sv | 68 ++++++
 rtl/ex_mem_stage.sv | 105 ++++++++++
 tb/tb_ex_mem_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types for the EX->MEM pipeline stage: branch encodings, the
// bundle carried from EX to MEM, and the skid-buffer occupancy states.
package ex_mem_pkg;

    localparam int DW_DEF  = 32;
    localparam int RAW_DEF = 5;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_GT   = 3'd4,
        BR_LE   = 3'd5,
        BR_GE   = 3'd6,
        BR_JMP  = 3'd7
    } branch_type_e;

    // Occupancy of the 2-entry skid buffer; the state value is the count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic [DW_DEF-1:0]  result;
        logic [DW_DEF-1:0]  store_data;
        logic [RAW_DEF-1:0] rd;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               mem_to_reg;
        logic               is_comp;
    } ex_mem_bundle_t;

    // Branch condition from the ALU flags; the flags come from the same
    // operation that produced the bundle.
    function automatic logic branch_taken(input branch_type_e bt,
                                          input logic zero,
                                          input logic lt,
                                          input logic gt);
        logic taken;
        taken = 1'b0;
        case (bt)
            BR_NONE: taken = 1'b0;
            BR_EQ:   taken = zero;
            BR_NE:   taken = ~zero;
            BR_LT:   taken = lt;
            BR_GT:   taken = gt;
            BR_LE:   taken = ~gt;
            BR_GE:   taken = ~lt;
            BR_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: a head register presented downstream and a skid
// register that catches the bundle accepted while the head is stalled.
// in_ready is decoded from the registered occupancy only, so the upstream
// never sees a combinational path from out_ready.
import ex_mem_pkg::*;

module pipe_skid_buf #(
    parameter type T = logic [31:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    occ_state_e r_state;
    T           r_head;
    T           r_skid;
    logic       w_accept;

    assign in_ready  = (r_state != OCC_TWO);
    assign out_valid = (r_state != OCC_EMPTY);
    assign out_data  = r_head;
    assign w_accept  = in_valid & in_ready & ~flush;

    // Occupancy FSM with head/skid data movement; flush wins over everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= OCC_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            r_state <= OCC_EMPTY;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_accept) begin
                        r_head  <= in_data;
                        r_state <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (w_accept && !out_ready) begin
                        r_skid  <= in_data;
                        r_state <= OCC_TWO;
                    end else if (w_accept && out_ready) begin
                        r_head  <= in_data;
                    end else if (out_ready) begin
                        r_state <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (out_ready) begin
                        r_head  <= r_skid;
                        r_state <= OCC_ONE;
                    end
                end
                default: r_state <= OCC_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: buffers the ALU bundle in a 2-entry skid buffer,
// resolves conditional branches at accept time and pulses a PC redirect.
// DW/RAW must stay equal to the package defaults that size the bundle.
import ex_mem_pkg::*;

module ex_mem_stage #(
    parameter int DW  = DW_DEF,
    parameter int RAW = RAW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  alu_result,
    input  logic           alu_zero,
    input  logic           alu_lt,
    input  logic           alu_gt,
    input  logic           alu_is_comp,
    input  logic [DW-1:0]  store_data,
    input  logic [RAW-1:0] rd_addr,
    input  logic           mem_read,
    input  logic           mem_write,
    input  logic           reg_write,
    input  logic           mem_to_reg,
    input  logic [2:0]     br_type,
    input  logic [DW-1:0]  br_target,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_result,
    output logic [DW-1:0]  out_store_data,
    output logic [RAW-1:0] out_rd,
    output logic           out_mem_read,
    output logic           out_mem_write,
    output logic           out_reg_write,
    output logic           out_mem_to_reg,
    output logic           out_is_comp,
    output logic           redirect_valid,
    output logic [DW-1:0]  redirect_pc
);

    logic           w_in_ready;
    logic           w_accept;
    logic           w_taken;
    ex_mem_bundle_t w_in_bundle;
    ex_mem_bundle_t w_out_bundle;
    logic           r_redirect_valid;
    logic [DW-1:0]  r_redirect_pc;

    assign w_taken  = branch_taken(branch_type_e'(br_type), alu_zero, alu_lt, alu_gt);
    assign w_accept = in_valid & w_in_ready & ~flush;

    // Pack the incoming bundle; a taken branch must never touch memory.
    always_comb begin
        w_in_bundle            = '0;
        w_in_bundle.result     = alu_result;
        w_in_bundle.store_data = store_data;
        w_in_bundle.rd         = rd_addr;
        w_in_bundle.mem_read   = mem_read  & ~w_taken;
        w_in_bundle.mem_write  = mem_write & ~w_taken;
        w_in_bundle.reg_write  = reg_write;
        w_in_bundle.mem_to_reg = mem_to_reg;
        w_in_bundle.is_comp    = alu_is_comp;
    end

    pipe_skid_buf #(
        .T (ex_mem_bundle_t)
    ) u_skid (
        .clk       (clk),
        .rst       (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .in_data   (w_in_bundle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_bundle)
    );

    // One-cycle redirect pulse for a taken branch; the PC holds between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_accept & w_taken;
            if (w_accept && w_taken) begin
                r_redirect_pc <= br_target;
            end
        end
    end

    assign in_ready       = w_in_ready;
    assign out_result     = w_out_bundle.result;
    assign out_store_data = w_out_bundle.store_data;
    assign out_rd         = w_out_bundle.rd;
    assign out_mem_read   = w_out_bundle.mem_read;
    assign out_mem_write  = w_out_bundle.mem_write;
    assign out_reg_write  = w_out_bundle.reg_write;
    assign out_mem_to_reg = w_out_bundle.mem_to_reg;
    assign out_is_comp    = w_out_bundle.is_comp;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, in_ready;
    logic [31:0] alu_result, store_data, br_target;
    logic        alu_zero, alu_lt, alu_gt, alu_is_comp;
    logic [4:0]  rd_addr;
    logic        mem_read, mem_write, reg_write, mem_to_reg;
    logic [2:0]  br_type;
    logic        out_valid, out_ready;
    logic [31:0] out_result, out_store_data;
    logic [4:0]  out_rd;
    logic        out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg, out_is_comp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    ex_mem_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_gt(alu_gt),
        .alu_is_comp(alu_is_comp), .store_data(store_data), .rd_addr(rd_addr),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .br_type(br_type), .br_target(br_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
        .out_is_comp(out_is_comp),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        mr, mw, rw, m2r, ic;
    } exp_t;

    exp_t        q[$];
    logic [31:0] obs[$];
    logic        exp_rv;
    logic [31:0] exp_rpc;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Branch rule table, written straight from the condition list.
    function automatic logic model_taken(input logic [2:0] bt, input logic z,
                                         input logic lt, input logic gt);
        case (bt)
            3'd0:    return 1'b0;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return lt;
            3'd4:    return gt;
            3'd5:    return !gt;
            3'd6:    return !lt;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_check();
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_rv});
        chk("redirect_pc", redirect_pc, exp_rpc);
        if (q.size() > 0) begin
            chk("out_result", out_result, q[0].res);
            chk("out_store_data", out_store_data, q[0].sd);
            chk("out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
            chk("out_ctl",
                {27'd0, out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg, out_is_comp},
                {27'd0, q[0].mr, q[0].mw, q[0].rw, q[0].m2r, q[0].ic});
        end
    endtask

    task automatic model_update();
        logic acc, drn, tk;
        exp_t e;
        acc = in_valid && (q.size() < 2) && !flush;
        drn = (q.size() > 0) && out_ready;
        tk  = model_taken(br_type, alu_zero, alu_lt, alu_gt);
        if (flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
                e.res = alu_result; e.sd = store_data; e.rd = rd_addr;
                e.mr  = tk ? 1'b0 : mem_read;
                e.mw  = tk ? 1'b0 : mem_write;
                e.rw  = reg_write; e.m2r = mem_to_reg; e.ic = alu_is_comp;
                q.push_back(e);
            end
        end
        exp_rv = acc && tk;
        if (acc && tk) exp_rpc = br_target;
    endtask

    // One clock: compare on the falling edge, advance the model, then return
    // 1 ns after the rising edge so the caller can drive the next inputs.
    task automatic step();
        @(negedge clk);
        model_check();
        if (out_valid && out_ready) obs.push_back(out_result);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; alu_result = 0; store_data = 0; br_target = 0;
        alu_zero = 0; alu_lt = 0; alu_gt = 0; alu_is_comp = 0; rd_addr = 0;
        mem_read = 0; mem_write = 0; reg_write = 0; mem_to_reg = 0; br_type = 0;
    endtask

    task automatic rand_inputs();
        flush       = ($urandom % 16) == 0;
        in_valid    = ($urandom % 10) < 7;
        out_ready   = ($urandom % 10) < 6;
        alu_result  = $urandom; store_data = $urandom; br_target = $urandom;
        alu_zero    = 1'($urandom); alu_lt = 1'($urandom); alu_gt = 1'($urandom);
        alu_is_comp = 1'($urandom); rd_addr = 5'($urandom);
        mem_read    = 1'($urandom); mem_write = 1'($urandom);
        reg_write   = 1'($urandom); mem_to_reg = 1'($urandom);
        br_type     = ($urandom % 2) == 0 ? 3'd0 : 3'($urandom);
    endtask

    task automatic offer(input logic [31:0] res);
        idle_inputs();
        in_valid = 1; alu_result = res; rd_addr = res[4:0]; reg_write = 1;
    endtask

    initial begin
        reset = 1; out_ready = 0;
        idle_inputs();
        exp_rv = 0; exp_rpc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        reset = 0;

        // Pass-through
        out_ready = 1;
        idle_inputs(); in_valid = 1; alu_result = 32'h5; rd_addr = 5'd3; reg_write = 1;
        step();
        $display("pass-through: out_valid=%0d out_result=%h out_rd=%0d", out_valid, out_result, out_rd);
        chk("pt_valid", {31'd0, out_valid}, 32'd1);
        chk("pt_result", out_result, 32'h5);
        chk("pt_rd", {27'd0, out_rd}, 32'd3);
        idle_inputs();
        step();

        // Backpressure: A, B fill, C held off, then drain in order
        obs.delete();
        out_ready = 0;
        offer(32'h11); step();
        offer(32'h22); step();
        chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        offer(32'h33); step(); step();
        chk("bp_head_held", out_result, 32'h11);
        out_ready = 1;
        step();
        step();
        idle_inputs();
        step(); step();
        $display("backpressure: drained %0d bundles", obs.size());
        chk("bp_count", obs.size(), 32'd3);
        if (obs.size() == 3) begin
            chk("bp_order0", obs[0], 32'h11);
            chk("bp_order1", obs[1], 32'h22);
            chk("bp_order2", obs[2], 32'h33);
        end

        // Branches
        idle_inputs(); in_valid = 1; br_type = 3'd1; alu_zero = 1; br_target = 32'h400; mem_write = 1;
        step();
        $display("beq: redirect_valid=%0d redirect_pc=%h", redirect_valid, redirect_pc);
        chk("beq_pulse", {31'd0, redirect_valid}, 32'd1);
        chk("beq_pc", redirect_pc, 32'h400);
        chk("beq_no_store", {31'd0, out_mem_write}, 32'd0);
        idle_inputs();
        step();
        chk("beq_pulse_end", {31'd0, redirect_valid}, 32'd0);
        chk("beq_pc_hold", redirect_pc, 32'h400);
        idle_inputs(); in_valid = 1; br_type = 3'd2; alu_zero = 1; br_target = 32'h500;
        step();
        chk("bne_no_pulse", {31'd0, redirect_valid}, 32'd0);
        idle_inputs(); in_valid = 1; br_type = 3'd6; alu_lt = 0; br_target = 32'h600;
        step();
        chk("bge_pulse", {31'd0, redirect_valid}, 32'd1);
        chk("bge_pc", redirect_pc, 32'h600);
        idle_inputs(); in_valid = 1; br_type = 3'd7; br_target = 32'h700;
        step();
        $display("jmp: redirect_valid=%0d redirect_pc=%h", redirect_valid, redirect_pc);
        chk("jmp_pulse", {31'd0, redirect_valid}, 32'd1);
        chk("jmp_pc", redirect_pc, 32'h700);
        idle_inputs();
        step(); step();

        // Flush with two held and D offered
        out_ready = 0;
        offer(32'hA1); step();
        offer(32'hA2); step();
        offer(32'hDD); flush = 1;
        step();
        $display("flush: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        idle_inputs(); out_ready = 1; obs.delete();
        repeat (3) step();
        chk("flush_nothing_out", obs.size(), 32'd0);

        // Throughput: 8 back-to-back bundles with continuous drain
        obs.delete(); out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            offer(32'h100 + i);
            step();
            chk("tp_in_ready", {31'd0, in_ready}, 32'd1);
            chk("tp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        idle_inputs();
        step();
        $display("throughput: drained %0d bundles", obs.size());
        chk("tp_count", obs.size(), 32'd8);
        for (int i = 0; i < 8 && i < obs.size(); i++) chk("tp_order", obs[i], 32'h100 + i);

        // Async reset mid-operation with a redirect pending
        out_ready = 0;
        offer(32'hB1); step();
        idle_inputs(); in_valid = 1; br_type = 3'd7; br_target = 32'h900;
        step();
        chk("pre_rst_pulse", {31'd0, redirect_valid}, 32'd1);
        idle_inputs();
        #2 reset = 1;
        #1;
        $display("async reset: out_valid=%0d in_ready=%0d redirect_valid=%0d", out_valid, in_ready, redirect_valid);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("arst_redirect_pc", redirect_pc, 32'd0);
        q.delete(); exp_rv = 0; exp_rpc = 0;
        @(posedge clk); #1;
        reset = 0;

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            step();
        end
        idle_inputs(); out_ready = 1;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
